// File: rtl/output_collector.sv
// Realigns skewed per-column systolic results, optionally adds partial sums with
// signed saturation, and writes each aligned row to the output buffer.
module output_collector #(
   parameter int WIDTH = 8,
   parameter int COL = 4,
   parameter int O_SIZE = 256,
   localparam int AW = $clog2(O_SIZE)
) (
   input  logic                       clk_i,
   input  logic                       rstn_sync_i,
   input  logic                       start_i,
   input  logic [AW-1:0]              o_rows_i,
   input  logic [AW-1:0]              o_offset_i,
   input  logic [AW-1:0]              psum_offset_i,
   input  logic                       accum_en_i,
   input  logic [COL-1:0]             col_valid_i,
   input  logic [COL-1:0][WIDTH-1:0]  col_data_i,
   output logic                       ps_mem_cenb_o,
   output logic                       ps_mem_wenb_o,
   output logic [AW-1:0]              ps_mem_addr_o,
   input  logic [COL-1:0][WIDTH-1:0]  ps_mem_data_i,
   output logic                       ob_mem_cenb_o,
   output logic                       ob_mem_wenb_o,
   output logic [AW-1:0]              ob_mem_addr_o,
   output logic [COL-1:0][WIDTH-1:0]  ob_mem_data_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                      state;
   logic [AW-1:0]               rows, o_off, ps_off, rd_cnt, wr_cnt;
   logic                        accum;
   logic                        run;
   logic [COL-1:0]              in_valid, pre_valid;
   logic [COL-1:0][WIDTH-1:0]   pre_data;
   logic                        launch, misalign;
   logic                        a_valid, b_valid;
   logic [COL-1:0][WIDTH-1:0]   a_data, b_data, sum;

   assign run = (state == RUN);
   assign in_valid = col_valid_i & {COL{run}};
   assign ps_mem_wenb_o = 1'b1;

   // Column c sees COL-1-c chain registers; the stage A register supplies the last one,
   // so every column of a row reaches stage A in the same cycle.
   generate
      for (genvar gi = 0; gi < COL; gi++) begin : g_col
         localparam int D = COL - 1 - gi;
         if (D == 0) begin : g_direct
            assign pre_valid[gi] = in_valid[gi];
            assign pre_data[gi]  = col_data_i[gi];
         end else begin : g_chain
            logic [D-1:0]            v_chain;
            logic [D-1:0][WIDTH-1:0] d_chain;
            always_ff @(posedge clk_i) begin
               if (!rstn_sync_i) begin
                  v_chain <= '0;
                  d_chain <= '0;
               end else begin
                  v_chain[0] <= in_valid[gi];
                  d_chain[0] <= col_data_i[gi];
                  for (int k = 1; k < D; k++) begin
                     v_chain[k] <= v_chain[k-1];
                     d_chain[k] <= d_chain[k-1];
                  end
               end
            end
            assign pre_valid[gi] = v_chain[D-1];
            assign pre_data[gi]  = d_chain[D-1];
         end

         // One extra bit of headroom; the top two bits disagree only on overflow.
         logic [WIDTH:0] ext_r, ext_p, wide;
         assign ext_r = {b_data[gi][WIDTH-1], b_data[gi]};
         assign ext_p = accum ? {ps_mem_data_i[gi][WIDTH-1], ps_mem_data_i[gi]} : '0;
         assign wide  = ext_r + ext_p;
         assign sum[gi] = (wide[WIDTH:WIDTH-1] == 2'b01) ? {1'b0, {(WIDTH-1){1'b1}}} :
                          (wide[WIDTH:WIDTH-1] == 2'b10) ? {1'b1, {(WIDTH-1){1'b0}}} :
                          wide[WIDTH-1:0];
      end
   endgenerate

   assign launch   = run && (&pre_valid) && (rd_cnt != rows);
   assign misalign = run && (|pre_valid) && !(&pre_valid);

   always_ff @(posedge clk_i) begin
      if (!rstn_sync_i) begin
         state         <= IDLE;
         rows          <= '0;
         o_off         <= '0;
         ps_off        <= '0;
         accum         <= 1'b0;
         rd_cnt        <= '0;
         wr_cnt        <= '0;
         a_valid       <= 1'b0;
         a_data        <= '0;
         b_valid       <= 1'b0;
         b_data        <= '0;
         ps_mem_cenb_o <= 1'b1;
         ps_mem_addr_o <= '0;
         ob_mem_cenb_o <= 1'b1;
         ob_mem_wenb_o <= 1'b1;
         ob_mem_addr_o <= '0;
         ob_mem_data_o <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         ps_mem_cenb_o <= 1'b1;
         ob_mem_cenb_o <= 1'b1;
         ob_mem_wenb_o <= 1'b1;

         a_valid <= launch;
         a_data  <= pre_data;
         if (launch) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (accum) begin
               ps_mem_cenb_o <= 1'b0;
               ps_mem_addr_o <= ps_off + rd_cnt;
            end
         end
         if (misalign)
            err_o <= 1'b1;

         b_valid <= a_valid;
         b_data  <= a_data;
         if (b_valid) begin
            ob_mem_cenb_o <= 1'b0;
            ob_mem_wenb_o <= 1'b0;
            ob_mem_addr_o <= o_off + wr_cnt;
            ob_mem_data_o <= sum;
            wr_cnt        <= wr_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  rows   <= o_rows_i;
                  o_off  <= o_offset_i;
                  ps_off <= psum_offset_i;
                  accum  <= accum_en_i;
                  rd_cnt <= '0;
                  wr_cnt <= '0;
                  err_o  <= 1'b0;
                  busy_o <= 1'b1;
                  if (o_rows_i == '0) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (wr_cnt == rows) begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b0;
               busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector: table vectors, directed corner sequences and random runs
// checked against a row-level model of deskew, partial-sum accumulation and saturation.
module tb_output_collector;
   localparam int WIDTH = 8;
   localparam int COL = 4;
   localparam int O_SIZE = 256;
   localparam int AW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rstn_sync_i, start_i, accum_en_i;
   logic [AW-1:0]             o_rows_i, o_offset_i, psum_offset_i;
   logic [COL-1:0]            col_valid_i;
   logic [COL-1:0][WIDTH-1:0] col_data_i, ps_mem_data_i, ob_mem_data_o;
   logic                      ps_mem_cenb_o, ps_mem_wenb_o, ob_mem_cenb_o, ob_mem_wenb_o;
   logic                      busy_o, done_o, err_o;
   logic [AW-1:0]             ps_mem_addr_o, ob_mem_addr_o;

   output_collector #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
      .clk_i(clk), .rstn_sync_i(rstn_sync_i), .start_i(start_i), .o_rows_i(o_rows_i),
      .o_offset_i(o_offset_i), .psum_offset_i(psum_offset_i), .accum_en_i(accum_en_i),
      .col_valid_i(col_valid_i), .col_data_i(col_data_i),
      .ps_mem_cenb_o(ps_mem_cenb_o), .ps_mem_wenb_o(ps_mem_wenb_o), .ps_mem_addr_o(ps_mem_addr_o),
      .ps_mem_data_i(ps_mem_data_i), .ob_mem_cenb_o(ob_mem_cenb_o), .ob_mem_wenb_o(ob_mem_wenb_o),
      .ob_mem_addr_o(ob_mem_addr_o), .ob_mem_data_o(ob_mem_data_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

   // Partial sum buffer: synchronous read, data one cycle after the request.
   logic [COL-1:0][WIDTH-1:0] psmem [O_SIZE];
   always @(posedge clk) if (!ps_mem_cenb_o) ps_mem_data_i <= psmem[ps_mem_addr_o];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [AW-1:0] addr; logic [31:0] data; } ev_t;
   ev_t  wr_q[$];
   ev_t  rd_q[$];
   int   done_q[$];
   logic err_at_done;

   always @(negedge clk) begin
      if (!ob_mem_cenb_o && !ob_mem_wenb_o) begin
         wr_q.push_back('{cyc, ob_mem_addr_o, ob_mem_data_o});
         $display("[cyc %0d] write addr=%0d data=%h", cyc, ob_mem_addr_o, ob_mem_data_o);
      end
      if (!ps_mem_cenb_o) rd_q.push_back('{cyc, ps_mem_addr_o, 32'd0});
      if (done_o) begin
         done_q.push_back(cyc);
         err_at_done <= err_o;
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Row stimulus shared by the run tasks.
   int                        n_rows;
   logic [COL-1:0][WIDTH-1:0] res [16];
   int                        tstart [16];
   int                        late_row, late_col;

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b, input bit acc);
      int s;
      s = int'($signed(a)) + (acc ? int'($signed(b)) : 0);
      if (s > 127) return 8'h7f;
      if (s < -128) return 8'h80;
      return s[7:0];
   endfunction

   function automatic logic [31:0] mk(input int a, input int b, input int c, input int d);
      logic [3:0][7:0] v;
      v[0] = a[7:0]; v[1] = b[7:0]; v[2] = c[7:0]; v[3] = d[7:0];
      return v;
   endfunction

   task automatic drive_rows(input int t0, input int rst_at);
      int maxk;
      maxk = 0;
      for (int r = 0; r < n_rows; r++) if (tstart[r] + COL + 1 > maxk) maxk = tstart[r] + COL + 1;
      for (int k = 0; k <= maxk; k++) begin
         for (int c = 0; c < COL; c++) begin
            logic v;
            logic [WIDTH-1:0] d;
            v = 1'b0;
            d = WIDTH'($urandom);
            for (int r = 0; r < n_rows; r++)
               if (tstart[r] + c + ((r == late_row && c == late_col) ? 1 : 0) == k) begin
                  v = 1'b1;
                  d = res[r][c];
               end
            col_valid_i[c] = v;
            col_data_i[c] = d;
         end
         if (k == rst_at) rstn_sync_i = 1'b0;
         @(posedge clk); #1;
      end
      col_valid_i = '0;
   endtask

   task automatic start_run(input int rows_cfg, input int ooff, input int psoff, input bit acc, output int t0);
      wr_q.delete(); rd_q.delete(); done_q.delete();
      @(posedge clk); #1;
      start_i = 1'b1; o_rows_i = AW'(rows_cfg); o_offset_i = AW'(ooff);
      psum_offset_i = AW'(psoff); accum_en_i = acc;
      @(posedge clk); #1;
      start_i = 1'b0;
      o_rows_i = AW'($urandom); o_offset_i = AW'($urandom);
      psum_offset_i = AW'($urandom); accum_en_i = 1'($urandom);
      t0 = cyc;
   endtask

   task automatic run_case(input int rows_cfg, input int ooff, input int psoff, input bit acc, input string tag);
      int launched[$];
      int nexp, t0, r, exp_done;
      logic [3:0][7:0] exp_row;
      for (int i = 0; i < n_rows; i++) if (i != late_row) launched.push_back(i);
      nexp = (launched.size() < rows_cfg) ? launched.size() : rows_cfg;
      start_run(rows_cfg, ooff, psoff, acc, t0);
      check({tag, "_busy"}, busy_o, 1);
      check({tag, "_err_clr"}, err_o, 0);
      drive_rows(t0, -1);
      for (int w = 0; w < 64 && done_q.size() == 0; w++) @(posedge clk);
      repeat (8) @(posedge clk);
      #1;
      check({tag, "_ndone"}, done_q.size(), 1);
      check({tag, "_nwrites"}, wr_q.size(), nexp);
      check({tag, "_nreads"}, rd_q.size(), acc ? nexp : 0);
      for (int i = 0; i < nexp; i++) begin
         r = launched[i];
         for (int c = 0; c < COL; c++)
            exp_row[c] = sat_add(res[r][c], psmem[(psoff + i) % O_SIZE][c], acc);
         if (i < wr_q.size()) begin
            check({tag, "_waddr"}, wr_q[i].addr, (ooff + i) % O_SIZE);
            check({tag, "_wdata"}, wr_q[i].data, exp_row);
            check({tag, "_wcyc"}, wr_q[i].cyc, t0 + tstart[r] + COL + 2);
         end
         if (acc && i < rd_q.size()) begin
            check({tag, "_raddr"}, rd_q[i].addr, (psoff + i) % O_SIZE);
            check({tag, "_rcyc"}, rd_q[i].cyc, t0 + tstart[r] + COL);
         end
      end
      exp_done = (nexp == 0) ? t0 : t0 + tstart[launched[nexp-1]] + COL + 3;
      if (done_q.size() > 0) begin
         check({tag, "_done_cyc"}, done_q[0], exp_done);
         check({tag, "_err"}, err_at_done, (late_row >= 0) ? 1 : 0);
      end
      check({tag, "_busy_end"}, busy_o, 0);
      $display("case %s: rows=%0d sent=%0d acc=%0d writes=%0d", tag, rows_cfg, n_rows, acc, wr_q.size());
   endtask

   typedef struct { logic [31:0] r; logic [31:0] p; bit acc; logic [31:0] e; } vec_t;
   vec_t vecs [5];

   initial begin
      int t0, psoff, ooff, rows_cfg;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, psoff, ooff, rows_cfg;
      vecs[0] = '{mk(100, -100, 3, 0), mk(50, -60, 4, -1), 1'b1, mk(127, -128, 7, -1)};
      vecs[1] = '{mk(100, -100, 3, 0), mk(50, -60, 4, -1), 1'b0, mk(100, -100, 3, 0)};
      vecs[2] = '{mk(127, -128, -1, 64), mk(1, -1, 1, 64), 1'b1, mk(127, -128, 0, 127)};
      vecs[3] = '{mk(-128, -128, 127, -5), mk(-128, 127, -128, 5), 1'b1, mk(-128, -1, -1, 0)};
      vecs[4] = '{mk(10, -20, 30, -40), mk(-10, 20, -30, 40), 1'b1, mk(0, 0, 0, 0)};
      for (int i = 0; i < O_SIZE; i++) psmem[i] = $urandom;
      late_row = -1; late_col = 0;

      // Reset with random inputs.
      rstn_sync_i = 1'b0;
      @(posedge clk); #1;
      wr_q.delete(); rd_q.delete(); done_q.delete();
      repeat (3) begin
         start_i = 1'($urandom); o_rows_i = AW'($urandom); o_offset_i = AW'($urandom);
         psum_offset_i = AW'($urandom); accum_en_i = 1'($urandom);
         col_valid_i = COL'($urandom); col_data_i = $urandom;
         @(posedge clk); #1;
      end
      check("rst_ps_cenb", ps_mem_cenb_o, 1);
      check("rst_ps_wenb", ps_mem_wenb_o, 1);
      check("rst_ob_cenb", ob_mem_cenb_o, 1);
      check("rst_ob_wenb", ob_mem_wenb_o, 1);
      check("rst_ps_addr", ps_mem_addr_o, 0);
      check("rst_ob_addr", ob_mem_addr_o, 0);
      check("rst_ob_data", ob_mem_data_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_strobes", wr_q.size() + rd_q.size() + done_q.size(), 0);
      start_i = 1'b0; col_valid_i = '0; rstn_sync_i = 1'b1;
      repeat (2) @(posedge clk);

      // Table vectors: single row, hand-computed expected write.
      for (int i = 0; i < 5; i++) begin
         n_rows = 1; tstart[0] = 0; res[0] = vecs[i].r;
         psoff = (i == 0) ? 5 : int'($urandom_range(0, 255));
         ooff = $urandom_range(0, 255);
         psmem[psoff] = vecs[i].p;
         run_case(1, ooff, psoff, vecs[i].acc, $sformatf("vec%0d", i));
         if (wr_q.size() > 0) check($sformatf("vec%0d_table", i), wr_q[0].data, vecs[i].e);
      end

      // Pass-through: four back-to-back rows.
      n_rows = 4;
      for (int r = 0; r < 4; r++) begin
         tstart[r] = r;
         res[r] = mk(4*r, 4*r+1, 4*r+2, 4*r+3);
      end
      run_case(4, 10, 0, 1'b0, "pass");

      // Wrap-around of both address counters.
      for (int r = 0; r < 4; r++) res[r] = $urandom;
      run_case(4, 254, 255, 1'b1, "wrap");

      // Misalignment: column 2 of row 1 one cycle late.
      n_rows = 3; tstart[0] = 0; tstart[1] = 6; tstart[2] = 12;
      late_row = 1; late_col = 2;
      run_case(2, 30, 40, 1'b1, "skew");
      late_row = -1;

      // Empty run; also confirms the error flag was cleared by start.
      n_rows = 0;
      run_case(0, 7, 9, 1'b1, "empty");

      // Random runs, some with extra rows that must be dropped.
      for (int n = 0; n < 10; n++) begin
         rows_cfg = $urandom_range(1, 8);
         n_rows = rows_cfg + int'($urandom_range(0, 2));
         tstart[0] = $urandom_range(0, 2);
         for (int r = 0; r < n_rows; r++) begin
            if (r > 0) tstart[r] = tstart[r-1] + int'($urandom_range(1, 3));
            res[r] = $urandom;
         end
         run_case(rows_cfg, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom),
                  $sformatf("rand%0d", n));
      end

      // Reset in the second write cycle of a four-row run.
      n_rows = 4;
      for (int r = 0; r < 4; r++) begin tstart[r] = r; res[r] = $urandom; end
      start_run(4, 100, 50, 1'b1, t0);
      drive_rows(t0, COL + 3);
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_writes", wr_q.size(), 2);
      check("mid_rst_done", done_q.size(), 0);
      check("mid_rst_ob_cenb", ob_mem_cenb_o, 1);
      check("mid_rst_ps_cenb", ps_mem_cenb_o, 1);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_addr", ob_mem_addr_o, 0);
      check("mid_rst_data", ob_mem_data_o, 0);
      rstn_sync_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_writes", wr_q.size(), 2);
      $display("case mid_reset: writes=%0d", wr_q.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/output_collector.md
# output_collector

Downstream stage of the systolic array inside `matrix_mult_wrapper`. It takes the skewed per-column results leaving the bottom edge of the array and realigns each result row. When accumulation is enabled, it adds the matching partial-sum row read from the partial sum buffer, with signed saturation. It then writes the aligned row to the output buffer memory and signals `done_o` after the configured number of rows.

## Interface
Parameters:
- `WIDTH`, 8: element width; signed two's complement.
- `COL`, 4: number of array columns.
- `O_SIZE`, 256: depth of the output buffer and partial sum buffer, in rows.

Ports:
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rstn_sync_i`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  one-cycle pulse; latches the configuration and starts a run.
- `o_rows_i`  in  $clog2(O_SIZE)  number of rows to collect; 0 means an empty run.
- `o_offset_i`  in  $clog2(O_SIZE)  output buffer base address.
- `psum_offset_i`  in  $clog2(O_SIZE)  partial sum buffer base address.
- `accum_en_i`  in  1  1 means add partial sums.
- `col_valid_i`  in  COL  per-column result valid.
- `col_data_i`  in  [COL-1:0][WIDTH-1:0]  per-column result.
- `ps_mem_cenb_o`  out  1  partial sum buffer chip enable, active-low.
- `ps_mem_wenb_o`  out  1  partial sum buffer write enable, active-low; tied 1 (read only).
- `ps_mem_addr_o`  out  $clog2(O_SIZE)  partial sum buffer read address.
- `ps_mem_data_i`  in  [COL-1:0][WIDTH-1:0]  partial sum read data; valid 1 cycle after the read request.
- `ob_mem_cenb_o`  out  1  output buffer chip enable, active-low.
- `ob_mem_wenb_o`  out  1  output buffer write enable, active-low.
- `ob_mem_addr_o`  out  $clog2(O_SIZE)  output buffer write address.
- `ob_mem_data_o`  out  [COL-1:0][WIDTH-1:0]  output buffer write data.
- `busy_o`  out  1  high while a run is in progress.
- `done_o`  out  1  one-cycle pulse at the end of a run.
- `err_o`  out  1  sticky skew-misalignment flag.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: on `start_i`, latch `o_rows_i`, `o_offset_i`, `psum_offset_i` and `accum_en_i`; clear the row counters and `err_o`. Go to DONE if `o_rows_i`==0, otherwise go to RUN.
  - RUN: collect rows. When the write count reaches `o_rows`, go to DONE.
  - DONE: `done_o`=1 for one cycle, then return to IDLE.
  - `start_i` outside IDLE is ignored. `col_valid_i` outside RUN is ignored.
- Input skew contract: result row r presents column c at cycle t_r+c.
- Deskew: column c passes through a register chain of depth COL-c. The whole row is therefore aligned at stage A in cycle t_r+COL.
  - If the aligned valid bits are not all equal, set `err_o`. Only an all-ones aligned valid launches a row.
- Stage A (row launch), in cycle t_r+COL:
  - If the latched accum flag is 1: issue a partial-sum read, `ps_mem_cenb_o`=0, `ps_mem_addr_o`=psum_offset+rd_cnt (mod O_SIZE).
  - Capture the aligned data into stage B.
- Stage B, in cycle t_r+COL+1:
  - Sum per element: result + psum if accum is on, else result alone.
  - Signed saturating add, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register the sum into the write stage.
- Write, in cycle t_r+COL+2:
  - `ob_mem_cenb_o`=0, `ob_mem_wenb_o`=0.
  - `ob_mem_addr_o`=o_offset+wr_cnt (mod O_SIZE); wraps naturally at O_SIZE-1 → 0.
  - `ob_mem_data_o`=sum; wr_cnt increments.
- Rows arriving after rd_cnt reaches `o_rows` are dropped.
- Back-to-back rows (t_{r+1}=t_r+1) are sustained at one write per cycle.

## Timing
- Reset values:
  - `ps_mem_cenb_o`=1, `ps_mem_wenb_o`=1, `ob_mem_cenb_o`=1, `ob_mem_wenb_o`=1.
  - Addresses 0, `ob_mem_data_o`=0.
  - `busy_o`=0, `done_o`=0, `err_o`=0.
  - State IDLE; deskew chains cleared.
- All outputs are registered.
- Latency: column 0 valid at cycle t → output buffer write in cycle t+COL+2. Latency is the same with accumulation on or off.
- `done_o` asserts the cycle after the final write.
- `busy_o`: high from the cycle after `start_i` through the `done_o` cycle.
- Empty run (`o_rows_i`=0): `done_o` asserts the cycle after `start_i`; no memory access.
- Reset asserted mid-run: all outputs take their reset values at the next edge; in-flight rows are discarded and no further writes occur.
- Memory strobes are inactive (1) in every cycle with no access.

## Test plan
- Reset: hold `rstn_sync_i`=0 for 3 cycles with random inputs → every output at its reset value; no strobe low.
- Pass-through: `accum_en`=0, `o_offset`=10, 4 skewed rows back-to-back, row r = {4r+3, 4r+2, 4r+1, 4r} → writes at addresses 10..13 in consecutive cycles, first write exactly COL+2 cycles after column 0 valid; `done_o` one cycle after the last write; `err_o`=0.
- Accumulate and saturate: `accum_en`=1, `psum_offset`=5, results {100, -100, 3, 0}, psums {50, -60, 4, -1} → `ps_mem_addr_o`=5 read once; written row {127, -128, 7, -1}.
- Wrap-around: `o_offset`=254 and `psum_offset`=255, 4 rows → output addresses 254, 255, 0, 1; psum addresses 255, 0, 1, 2.
- Misalignment: column 2 valid one cycle late for row 1 → `err_o`=1 and stays 1 through `done_o`; cleared by the next `start_i`.
- Boundary: `o_rows_i`=0 → `done_o` one cycle after start, no strobes. Separately, reset asserted after 2 of 4 writes → no further writes, all outputs at reset values.
